// File: rtl/control_unit.sv
// ============================================================================
// control_unit : Moore FSM sequencing the K&S data_path
//                (fetch, decode, execute, PC update).
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNEG   = 4'd10,
    I_BNNEG  = 4'd11,
    I_BOV    = 4'd12,
    I_BNOV   = 4'd13,
    I_HALT   = 4'd14
  } decoded_instruction_type;
endpackage

module control_unit
  import k_and_s_pkg::*;
#(
  parameter int INIT_CYCLES     = 1,
  parameter bit BOV_USES_SIGNED = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halted
);

  localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(INIT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd3,
    S_STORE  = 4'd4,
    S_ALU    = 4'd5,
    S_MOVE   = 4'd6,
    S_BRANCH = 4'd7,
    S_NEXT   = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_w;

  assign ovf_w = BOV_USES_SIGNED ? signed_overflow : unsigned_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        if (cnt_q == C_CNT_LAST) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (decoded_instruction)
          I_LOAD:                      state_d = S_LOAD;
          I_STORE:                     state_d = S_STORE;
          I_ADD, I_SUB, I_AND, I_OR:   state_d = S_ALU;
          I_MOVE:                      state_d = S_MOVE;
          I_HALT:                      state_d = S_HALT;
          I_BRANCH:                    state_d = S_BRANCH;
          I_BZERO:  state_d = zero_op ? S_BRANCH : S_NEXT;
          I_BNEG:   state_d = neg_op  ? S_BRANCH : S_NEXT;
          I_BNNEG:  state_d = !neg_op ? S_BRANCH : S_NEXT;
          I_BOV:    state_d = ovf_w   ? S_BRANCH : S_NEXT;
          I_BNOV:   state_d = !ovf_w  ? S_BRANCH : S_NEXT;
          default:                     state_d = S_NEXT;
        endcase
      end
      S_LOAD, S_STORE, S_ALU, S_MOVE: state_d = S_NEXT;
      S_BRANCH, S_NEXT:               state_d = S_FETCH;
      S_HALT:                         state_d = S_HALT;
      default:                        state_d = S_INIT;
    endcase
  end

  // Outputs are pure state decode so an async reset drops every strobe at once.
  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = 2'b00;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halted           = 1'b0;
    case (state_q)
      S_FETCH: begin
        addr_sel  = 1'b1;
        ir_enable = 1'b1;
      end
      S_LOAD: begin
        write_reg_enable = 1'b1;
      end
      S_STORE: begin
        ram_write_enable = 1'b1;
      end
      S_ALU: begin
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1;
        case (decoded_instruction)
          I_AND:   operation = 2'b01;
          I_OR:    operation = 2'b10;
          I_SUB:   operation = 2'b11;
          default: operation = 2'b00;
        endcase
      end
      S_MOVE: begin
        c_sel            = 1'b1;
        operation        = 2'b10;
        write_reg_enable = 1'b1;
      end
      S_BRANCH: begin
        pc_enable = 1'b1;
        branch    = 1'b1;
      end
      S_NEXT: begin
        pc_enable = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// tb_control_unit : scoreboard bench driving two control_unit instances that
//                   differ only in which overflow flag BOV/BNOV test.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_control_unit;
  import k_and_s_pkg::*;

  // Packed output order: {halted, ram_we, flags_en, wr_en, op[1:0], c_sel, addr_sel, ir_en, pc_en, branch}
  localparam logic [10:0] V_Z     = 11'b0_0_0_0_00_0_0_0_0_0;
  localparam logic [10:0] V_FETCH = 11'b0_0_0_0_00_0_1_1_0_0;
  localparam logic [10:0] V_NEXT  = 11'b0_0_0_0_00_0_0_0_1_0;
  localparam logic [10:0] V_BR    = 11'b0_0_0_0_00_0_0_0_1_1;
  localparam logic [10:0] V_LOAD  = 11'b0_0_0_1_00_0_0_0_0_0;
  localparam logic [10:0] V_STORE = 11'b0_1_0_0_00_0_0_0_0_0;
  localparam logic [10:0] V_MOVE  = 11'b0_0_0_1_10_1_0_0_0_0;
  localparam logic [10:0] V_HALT  = 11'b1_0_0_0_00_0_0_0_0_0;
  localparam logic [10:0] V_ADD   = 11'b0_0_1_1_00_1_0_0_0_0;
  localparam logic [10:0] V_AND   = 11'b0_0_1_1_01_1_0_0_0_0;
  localparam logic [10:0] V_OR    = 11'b0_0_1_1_10_1_0_0_0_0;
  localparam logic [10:0] V_SUB   = 11'b0_0_1_1_11_1_0_0_0_0;

  logic                    clk = 1'b0;
  logic                    rst_n;
  decoded_instruction_type di;
  logic                    zf, nf, uf, sf;

  logic       br_u, pc_u, ir_u, as_u, cs_u, wr_u, fl_u, rw_u, h_u;
  logic       br_s, pc_s, ir_s, as_s, cs_s, wr_s, fl_s, rw_s, h_s;
  logic [1:0] op_u, op_s;
  logic [10:0] vu, vs;

  assign vu = {h_u, rw_u, fl_u, wr_u, op_u, cs_u, as_u, ir_u, pc_u, br_u};
  assign vs = {h_s, rw_s, fl_s, wr_s, op_s, cs_s, as_s, ir_s, pc_s, br_s};

  control_unit #(.INIT_CYCLES(1), .BOV_USES_SIGNED(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .decoded_instruction(di),
    .zero_op(zf), .neg_op(nf), .unsigned_overflow(uf), .signed_overflow(sf),
    .branch(br_u), .pc_enable(pc_u), .ir_enable(ir_u), .addr_sel(as_u),
    .c_sel(cs_u), .operation(op_u), .write_reg_enable(wr_u),
    .flags_reg_enable(fl_u), .ram_write_enable(rw_u), .halted(h_u)
  );

  control_unit #(.INIT_CYCLES(1), .BOV_USES_SIGNED(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .decoded_instruction(di),
    .zero_op(zf), .neg_op(nf), .unsigned_overflow(uf), .signed_overflow(sf),
    .branch(br_s), .pc_enable(pc_s), .ir_enable(ir_s), .addr_sel(as_s),
    .c_sel(cs_s), .operation(op_s), .write_reg_enable(wr_s),
    .flags_reg_enable(fl_s), .ram_write_enable(rw_s), .halted(h_s)
  );

  always #5 clk = ~clk;

  logic [21:0] sb[$];
  logic [21:0] m_exp;
  int          checks   = 0;
  int          failures = 0;
  int          cyc_n    = 0;
  bit          mon_en   = 1'b0;
  bit          fin      = 1'b0;
  bit          fin_seen = 1'b0;

  // Monitor: one expected output vector per clock cycle, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow cycle=%0d got u=%b s=%b required a queued expectation",
                 cyc_n, vu, vs);
      end else begin
        m_exp = sb.pop_front();
        if ({vu, vs} !== m_exp) begin
          failures++;
          $display("FAIL outputs cycle=%0d got u=%b s=%b required u=%b s=%b",
                   cyc_n, vu, vs, m_exp[21:11], m_exp[10:0]);
        end
      end
      cyc_n++;
    end else if (fin && !fin_seen) begin
      fin_seen = 1'b1;
      checks++;
      if (sb.size() != 0) begin
        failures++;
        $display("FAIL sb_leftover got %0d entries required 0", sb.size());
      end
    end
  end

  task automatic cyc(input logic [10:0] eu, input logic [10:0] es);
    sb.push_back({eu, es});
    @(posedge clk);
    #1;
  endtask

  // Called while in S_FETCH; e1 is the first post-decode cycle, len=2 adds S_NEXT.
  task automatic run(input decoded_instruction_type ins, input logic z, input logic n,
                     input logic u, input logic s, input logic [10:0] e1u,
                     input logic [10:0] e1s, input int len);
    di = ins; zf = z; nf = n; uf = u; sf = s;
    cyc(V_FETCH, V_FETCH);
    cyc(V_Z, V_Z);
    cyc(e1u, e1s);
    if (len == 2) cyc(V_NEXT, V_NEXT);
  endtask

  initial begin
    rst_n = 1'b0;
    di    = I_NOP;
    zf = 1'b0; nf = 1'b0; uf = 1'b0; sf = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    repeat (3) cyc(V_Z, V_Z);
    rst_n = 1'b1;
    cyc(V_Z, V_Z);

    run(I_ADD,    0, 0, 0, 0, V_ADD,   V_ADD,   2);
    run(I_SUB,    1, 1, 1, 1, V_SUB,   V_SUB,   2);
    run(I_AND,    0, 0, 0, 0, V_AND,   V_AND,   2);
    run(I_OR,     0, 0, 0, 0, V_OR,    V_OR,    2);
    run(I_LOAD,   0, 0, 0, 0, V_LOAD,  V_LOAD,  2);
    run(I_MOVE,   0, 0, 0, 0, V_MOVE,  V_MOVE,  2);
    run(I_NOP,    0, 0, 0, 0, V_NEXT,  V_NEXT,  1);
    run(decoded_instruction_type'(4'hF), 1, 1, 1, 1, V_NEXT, V_NEXT, 1);
    run(I_BRANCH, 0, 0, 0, 0, V_BR,    V_BR,    1);
    run(I_BZERO,  1, 0, 0, 0, V_BR,    V_BR,    1);
    run(I_BZERO,  0, 1, 1, 1, V_NEXT,  V_NEXT,  1);
    run(I_BNEG,   0, 1, 0, 0, V_BR,    V_BR,    1);
    run(I_BNEG,   1, 0, 0, 0, V_NEXT,  V_NEXT,  1);
    run(I_BNNEG,  0, 0, 0, 0, V_BR,    V_BR,    1);
    run(I_BNNEG,  0, 1, 0, 0, V_NEXT,  V_NEXT,  1);
    run(I_BOV,    0, 0, 1, 0, V_BR,    V_NEXT,  1);
    run(I_BOV,    0, 0, 0, 1, V_NEXT,  V_BR,    1);
    run(I_BNOV,   0, 0, 1, 0, V_NEXT,  V_BR,    1);
    run(I_BNOV,   0, 0, 0, 1, V_BR,    V_NEXT,  1);
    run(I_STORE,  0, 0, 0, 0, V_STORE, V_STORE, 2);

    di = I_HALT;
    cyc(V_FETCH, V_FETCH);
    cyc(V_Z, V_Z);
    repeat (20) cyc(V_HALT, V_HALT);
    rst_n = 1'b0;
    cyc(V_Z, V_Z);
    rst_n = 1'b1;
    cyc(V_Z, V_Z);

    run(I_ADD, 0, 0, 0, 0, V_ADD, V_ADD, 2);

    // Reset lands part-way through the S_ALU cycle, before the monitor samples it.
    di = I_ADD;
    cyc(V_FETCH, V_FETCH);
    cyc(V_Z, V_Z);
    sb.push_back({V_Z, V_Z});
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(V_Z, V_Z);
    run(I_OR, 0, 0, 0, 0, V_OR, V_OR, 2);

    mon_en = 1'b0;
    fin    = 1'b1;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
